// File: rtl/pwm_cmd_pkg.sv
// Shared constants, status codes, parser state type and CRC-8 (poly 0x07) byte step
// for the PWM command controller.
package pwm_cmd_pkg;

   localparam logic [7:0]  HDR       = 8'h55;
   localparam logic [7:0]  FTR       = 8'hAA;
   localparam int unsigned FRAME_LEN = 14;
   localparam int unsigned RESP_LEN  = 6;

   localparam logic [7:0]  FUNC_CFG  = 8'h01;
   localparam logic [7:0]  FUNC_EN   = 8'h02;

   localparam logic [7:0]  ST_OK     = 8'h00;
   localparam logic [7:0]  ST_CRC    = 8'h01;
   localparam logic [7:0]  ST_ARG    = 8'h02;

   typedef enum logic [2:0] {
      S_HUNT,
      S_RECV,
      S_CHECK,
      S_EXEC,
      S_RESP
   } state_t;

   // MSB-first CRC-8, polynomial 0x07, no reflection.
   function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/crc8_07.sv
// Byte-serial CRC-8 (poly 0x07, init 0x00) accumulator; i_init clears, i_valid folds in a byte.
module crc8_07
   import pwm_cmd_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_init,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic [7:0] o_crc
);

   logic [7:0] r_crc;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_init) begin
         r_crc <= '0;
      end else if (i_valid) begin
         r_crc <= crc8_next(r_crc, i_data);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/pwm_cmd_ctrl.sv
// Host command parser: assembles 14-byte frames, checks footer/CRC/arguments,
// applies channel config or enable writes and returns a 6-byte status response.
module pwm_cmd_ctrl
   import pwm_cmd_pkg::*;
#(
   parameter int unsigned NUM_CH      = 6,
   parameter int unsigned CLK_FREQ    = 50000000,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              cfg_wr,
   output logic [7:0]        cfg_ch,
   output logic [7:0]        cfg_duty,
   output logic [15:0]       cfg_dessert,
   output logic [7:0]        cfg_pulse_num,
   output logic [31:0]       cfg_pat,
   output logic [NUM_CH-1:0] ch_en,
   output logic [7:0]        err_crc_cnt
);

   // A zero timeout falls back to 1 ms at the system clock.
   localparam int unsigned TMO_LIMIT = (TIMEOUT_CYC == 0) ? CLK_FREQ / 1000 : TIMEOUT_CYC;
   localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);
   localparam logic [7:0]  CH_MAX    = 8'(NUM_CH);

   state_t            r_state;
   logic [3:0]        r_idx;
   logic [TMO_W-1:0]  r_tmo;
   logic [7:0]        r_frame [1:13];
   logic [7:0]        r_status;
   logic [2:0]        r_ridx;
   logic [7:0]        r_tx_data;
   logic              r_tx_valid;
   logic              r_cfg_wr;
   logic [7:0]        r_cfg_ch;
   logic [7:0]        r_cfg_duty;
   logic [15:0]       r_cfg_dessert;
   logic [7:0]        r_cfg_pulse_num;
   logic [31:0]       r_cfg_pat;
   logic [NUM_CH-1:0] r_ch_en;
   logic [7:0]        r_err;

   logic [7:0] w_crc_frm;
   logic [7:0] w_crc_rsp;
   logic [7:0] w_status;
   logic [2:0] w_resp_sel;
   logic [7:0] w_resp_byte;
   logic       w_frm_valid;
   logic       w_rsp_valid;
   logic [7:0] w_rsp_data;
   logic       w_hunt;

   assign w_hunt      = (r_state == S_HUNT);
   assign w_frm_valid = (r_state == S_RECV) && rx_valid && (r_idx <= 4'd11);
   // Response CRC covers reg_func and ch as they arrive, then the status decided in CHECK.
   assign w_rsp_valid = ((r_state == S_RECV) && rx_valid && (r_idx == 4'd1 || r_idx == 4'd2))
                      || (r_state == S_CHECK);
   assign w_rsp_data  = (r_state == S_CHECK) ? w_status : rx_data;

   crc8_07 u_crc_frame (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_init  (w_hunt),
      .i_valid (w_frm_valid),
      .i_data  (rx_data),
      .o_crc   (w_crc_frm)
   );

   crc8_07 u_crc_resp (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_init  (w_hunt),
      .i_valid (w_rsp_valid),
      .i_data  (w_rsp_data),
      .o_crc   (w_crc_rsp)
   );

   always_comb begin
      w_status = ST_OK;
      if (w_crc_frm != r_frame[12]) begin
         w_status = ST_CRC;
      end else if (r_frame[2] == 8'd0 || r_frame[2] > CH_MAX
                   || (r_frame[1] != FUNC_CFG && r_frame[1] != FUNC_EN)) begin
         w_status = ST_ARG;
      end
   end

   always_comb begin
      w_resp_sel = r_tx_valid ? r_ridx + 3'd1 : r_ridx;
      case (w_resp_sel)
         3'd0:    w_resp_byte = HDR;
         3'd1:    w_resp_byte = r_frame[1];
         3'd2:    w_resp_byte = r_frame[2];
         3'd3:    w_resp_byte = r_status;
         3'd4:    w_resp_byte = w_crc_rsp;
         default: w_resp_byte = FTR;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state         <= S_HUNT;
         r_idx           <= '0;
         r_tmo           <= '0;
         for (int unsigned i = 1; i <= 13; i++) r_frame[i] <= '0;
         r_status        <= '0;
         r_ridx          <= '0;
         r_tx_data       <= '0;
         r_tx_valid      <= 1'b0;
         r_cfg_wr        <= 1'b0;
         r_cfg_ch        <= '0;
         r_cfg_duty      <= '0;
         r_cfg_dessert   <= '0;
         r_cfg_pulse_num <= '0;
         r_cfg_pat       <= '0;
         r_ch_en         <= '0;
         r_err           <= '0;
      end else begin
         r_cfg_wr <= 1'b0;
         case (r_state)
            S_HUNT: begin
               if (rx_valid && rx_data == HDR) begin
                  r_state <= S_RECV;
                  r_idx   <= 4'd1;
                  r_tmo   <= '0;
               end
            end
            S_RECV: begin
               if (rx_valid) begin
                  r_frame[r_idx] <= rx_data;
                  r_tmo          <= '0;
                  if (r_idx == 4'(FRAME_LEN - 1)) r_state <= S_CHECK;
                  else                            r_idx   <= r_idx + 4'd1;
               end else if (r_tmo == TMO_W'(TMO_LIMIT - 1)) begin
                  r_state <= S_HUNT;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_CHECK: begin
               if (r_frame[13] != FTR) begin
                  r_state <= S_HUNT;
               end else begin
                  r_status <= w_status;
                  if (w_status == ST_CRC && r_err != 8'hFF) r_err <= r_err + 8'd1;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_status == ST_OK) begin
                  if (r_frame[1] == FUNC_CFG) begin
                     r_cfg_wr        <= 1'b1;
                     r_cfg_ch        <= r_frame[2];
                     r_cfg_duty      <= r_frame[4];
                     r_cfg_dessert   <= {r_frame[5], r_frame[6]};
                     r_cfg_pulse_num <= r_frame[7];
                     r_cfg_pat       <= {r_frame[8], r_frame[9], r_frame[10], r_frame[11]};
                  end else begin
                     for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (r_frame[2] == 8'(i + 1)) r_ch_en[i] <= r_frame[3][0];
                     end
                  end
               end
               r_ridx  <= '0;
               r_state <= S_RESP;
            end
            S_RESP: begin
               // tx_valid stays high across bytes; the next byte is loaded on each handshake.
               if (!r_tx_valid) begin
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= w_resp_byte;
               end else if (tx_ready) begin
                  if (r_ridx == 3'(RESP_LEN - 1)) begin
                     r_tx_valid <= 1'b0;
                     r_state    <= S_HUNT;
                  end else begin
                     r_ridx    <= r_ridx + 3'd1;
                     r_tx_data <= w_resp_byte;
                  end
               end
            end
            default: r_state <= S_HUNT;
         endcase
      end
   end

   assign tx_data       = r_tx_data;
   assign tx_valid      = r_tx_valid;
   assign cfg_wr        = r_cfg_wr;
   assign cfg_ch        = r_cfg_ch;
   assign cfg_duty      = r_cfg_duty;
   assign cfg_dessert   = r_cfg_dessert;
   assign cfg_pulse_num = r_cfg_pulse_num;
   assign cfg_pat       = r_cfg_pat;
   assign ch_en         = r_ch_en;
   assign err_crc_cnt   = r_err;

endmodule

// File: doc/pwm_cmd_ctrl.md
Name: pwm_cmd_ctrl

Overview:
Command controller between the board's UART receiver/transmitter and the PWM channel bank. It assembles 14-byte host frames and validates header, footer and CRC-8. Valid frames become channel configuration writes or enable/disable updates. Every complete frame produces a 6-byte status response toward the UART transmitter.

Parameters:
NUM_CH, 6, number of PWM channels (valid channel numbers 1..NUM_CH; channel n maps to bit n-1)
CLK_FREQ, 50000000, sys_clk frequency in Hz
TIMEOUT_CYC, 50000, idle sys_clk cycles inside a frame before the parser aborts (1 ms)

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  synchronous active-low reset
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
tx_data  out  8  response byte
tx_valid  out  1  response byte valid; held until tx_ready
tx_ready  in  1  transmitter accepts tx_data when high with tx_valid
cfg_wr  out  1  one-cycle configuration write strobe
cfg_ch  out  8  target channel number (1-based)
cfg_duty  out  8  duty_num
cfg_dessert  out  16  pulse_dessert {H,L}
cfg_pulse_num  out  8  pulse count
cfg_pat  out  32  pattern {pat1,pat2,pat3,pat4}, pat1 is the MSB
ch_en  out  NUM_CH  channel enable register
err_crc_cnt  out  8  saturating count of CRC failures

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous, active-low (sys_rst_n sampled on the sys_clk rising edge).
- Reset values: all outputs 0; parser in HUNT.
- Frame layout: byte0 0x55, reg_func, ch, ctrl_sta, duty, dess_H, dess_L, pulse_num, pat1..pat4, crc, byte13 0xAA.
- CRC: CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, computed over bytes 1..11. Computed one byte per rx_valid.
- FSM states:
  - HUNT: wait for rx_valid with 0x55. Any other byte is discarded. Go to RECV with index=1.
  - RECV: store each byte. At index 13 go to CHECK.
  - CHECK: one cycle. Frame status is selected by priority:
    - footer != 0xAA: discard silently, no response, back to HUNT.
    - CRC mismatch: status 0x01, increment err_crc_cnt (saturate at 0xFF).
    - ch outside 1..NUM_CH, or reg_func not 0x01/0x02: status 0x02.
    - otherwise status 0x00.
  - EXEC: one cycle; acts only when status is 0x00.
    - reg_func 0x01: pulse cfg_wr. The cfg_* fields are registered the same cycle and held until the next write.
    - reg_func 0x02: ch_en[ch-1] <= ctrl_sta[0]; other bits unchanged.
  - RESP: send 55, reg_func, ch, status, crc8(bytes 1..3 of the response), AA. Each byte is held on tx_data with tx_valid until tx_ready; then return to HUNT.
- Bytes arriving during CHECK/EXEC/RESP are ignored. The host must wait for the response.
- Timeout: in RECV, if TIMEOUT_CYC cycles pass without rx_valid, return to HUNT. No response; no register change.
- A 0x55 byte mid-frame is treated as data, not as resync.
- Latency: cfg_wr or ch_en update occurs 2 cycles after the rx_valid of byte13. tx_valid rises 3 cycles after it.
- Reset mid-frame or mid-response: immediate return to reset values; a partially sent response is abandoned.

Decomposition:
- Shared package pwm_cmd_pkg holds:
  - constants HDR=8'h55, FTR=8'hAA, FRAME_LEN=14, RESP_LEN=6;
  - FUNC_CFG=8'h01, FUNC_EN=8'h02;
  - ST_OK/ST_CRC/ST_ARG status codes;
  - the state enum typedef.
- Sub-module crc8_07: byte-serial CRC-8 update with inputs init/valid/data and output crc. It is instantiated twice, once for frame check and once for response generation.

Test Plan:
- Send 55 02 01 01 00×8 2F AA, tx_ready=1 -> ch_en=6'b000001. Response 55 02 01 00 xx AA, where xx is CRC-8 of 02 01 00.
- Send 55 01 02 00 01 00 01 00 00 00 00 01 F2 AA -> single cfg_wr. Expect cfg_ch=2, duty=1, dessert=0x0001, pulse_num=0, pat=0x00000001; status 00.
- Send 55 02 01 00 00×8 55 AA (correct CRC is 56) -> ch_en unchanged, err_crc_cnt=1, status 01. Then resend with 56 -> ch_en[0]=0.
- Send ch=0x07 with correct CRC -> no write, status 02. Send footer 0xAB -> no response at all.
- Send 5 bytes then idle >TIMEOUT_CYC, then a full valid frame -> only the second frame executes and responds.
- Hold tx_ready=0 for 100 cycles during RESP -> tx_data/tx_valid stable; all 6 bytes delivered in order after release. Assert sys_rst_n=0 mid-response -> tx_valid=0 next cycle.
